// File: rtl/dff_ec_serial_tx.sv
// MSB-first serial transmitter driving a chain of DFFs with active-low capture enable.
// D, READY, BUSY and DONE are registered; EC follows HOLD combinationally so a stall never drops a bit.
module dff_ec_serial_tx #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned PARITY = 0
) (
   input  logic             C,
   input  logic             nR,
   input  logic [WIDTH-1:0] DIN,
   input  logic             LOAD,
   input  logic             HOLD,
   output logic             READY,
   output logic             BUSY,
   output logic             D,
   output logic             EC,
   output logic             DONE
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_PAR   = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_cnt;
   logic             r_par;

   // Receiver captures only while a bit is on D and the receiving side is not stalling.
   assign EC = ~((r_state == S_SHIFT) || (r_state == S_PAR)) | HOLD;

   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_par   <= 1'b0;
         READY   <= 1'b1;
         BUSY    <= 1'b0;
         D       <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (LOAD) begin
                  r_shreg <= DIN;
                  D       <= DIN[WIDTH-1];
                  r_cnt   <= '0;
                  r_par   <= ^DIN;
                  r_state <= S_SHIFT;
                  READY   <= 1'b0;
                  BUSY    <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (!HOLD) begin
                  if (r_cnt != LAST) begin
                     r_shreg <= r_shreg << 1;
                     D       <= r_shreg[WIDTH-2];
                     r_cnt   <= r_cnt + 1'b1;
                  end else if (PARITY != 0) begin
                     D       <= r_par;
                     r_state <= S_PAR;
                  end else begin
                     r_state <= S_IDLE;
                     D       <= 1'b0;
                     BUSY    <= 1'b0;
                     READY   <= 1'b1;
                     DONE    <= 1'b1;
                  end
               end
            end
            S_PAR: begin
               if (!HOLD) begin
                  r_state <= S_IDLE;
                  D       <= 1'b0;
                  BUSY    <= 1'b0;
                  READY   <= 1'b1;
                  DONE    <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dff_ec_serial_tx.sv
// Bench for dff_ec_serial_tx: three configurations checked against a frame-level model every cycle.
module tb_dff_ec_serial_tx;

   logic        clk;
   logic        rst_n;
   logic [31:0] din_a [3];
   logic [2:0]  load;
   logic [2:0]  hold;
   logic [2:0]  ready, busy, d, ec, done;

   int checks = 0;
   int errors = 0;

   // Model state: a frame is a list of bits sent MSB-first, advanced on every non-stalled edge.
   bit          m_busy [3];
   bit          m_done [3];
   int          m_idx  [3];
   int          m_nb   [3];
   logic [32:0] m_bits [3];
   // Receiver chain observed from the DUT pins.
   logic [32:0] rx [3];
   int          xf [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dff_ec_serial_tx #(.WIDTH(8), .PARITY(0)) u_a (
      .C(clk), .nR(rst_n), .DIN(din_a[0][7:0]), .LOAD(load[0]), .HOLD(hold[0]),
      .READY(ready[0]), .BUSY(busy[0]), .D(d[0]), .EC(ec[0]), .DONE(done[0]));
   dff_ec_serial_tx #(.WIDTH(8), .PARITY(1)) u_b (
      .C(clk), .nR(rst_n), .DIN(din_a[1][7:0]), .LOAD(load[1]), .HOLD(hold[1]),
      .READY(ready[1]), .BUSY(busy[1]), .D(d[1]), .EC(ec[1]), .DONE(done[1]));
   dff_ec_serial_tx #(.WIDTH(2), .PARITY(0)) u_c (
      .C(clk), .nR(rst_n), .DIN(din_a[2][1:0]), .LOAD(load[2]), .HOLD(hold[2]),
      .READY(ready[2]), .BUSY(busy[2]), .D(d[2]), .EC(ec[2]), .DONE(done[2]));

   function automatic int wof(input int i);
      return (i == 2) ? 2 : 8;
   endfunction

   function automatic int pof(input int i);
      return (i == 1) ? 1 : 0;
   endfunction

   function automatic logic [32:0] frame_bits(input int i, input logic [31:0] x);
      logic [31:0] m;
      m = x & ((32'd1 << wof(i)) - 32'd1);
      return (pof(i) != 0) ? {m, ^m} : {1'b0, m};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b0;
            m_idx[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!ec[i]) begin
               rx[i] <= {rx[i][31:0], d[i]};
               xf[i] <= xf[i] + 1;
            end
            if (!m_busy[i]) begin
               m_done[i] <= 1'b0;
               if (load[i]) begin
                  m_busy[i] <= 1'b1;
                  m_idx[i]  <= 0;
                  m_nb[i]   <= wof(i) + pof(i);
                  m_bits[i] <= frame_bits(i, din_a[i]);
                  rx[i]     <= '0;
                  xf[i]     <= 0;
               end
            end else if (!hold[i]) begin
               if (m_idx[i] + 1 == m_nb[i]) begin
                  m_busy[i] <= 1'b0;
                  m_done[i] <= 1'b1;
               end else begin
                  m_idx[i] <= m_idx[i] + 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic e_d;
         e_d = m_busy[i] ? m_bits[i][m_nb[i] - 1 - m_idx[i]] : 1'b0;
         chk($sformatf("inst%0d READY", i), 64'(ready[i]), 64'(!m_busy[i]));
         chk($sformatf("inst%0d BUSY", i),  64'(busy[i]),  64'(m_busy[i]));
         chk($sformatf("inst%0d D", i),     64'(d[i]),     64'(e_d));
         chk($sformatf("inst%0d EC", i),    64'(ec[i]),    64'(!m_busy[i] | hold[i]));
         chk($sformatf("inst%0d DONE", i),  64'(done[i]),  64'(m_done[i]));
      end
   end

   task automatic start(input int idx, input logic [31:0] w, input bit keep);
      @(posedge clk); #1;
      din_a[idx] = w;
      load[idx]  = 1'b1;
      @(posedge clk); #1;
      load[idx]  = keep;
      din_a[idx] = ~w;
   endtask

   // n = edges after the accepting edge until DONE is observed.
   task automatic track(input int idx, input int hold_from, input int hold_len,
                        input int pulse_at, input bit keep, output int n);
      bit ok;
      ok = 1'b0;
      n  = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         hold[idx] = (hold_len > 0) && (n >= hold_from) && (n < hold_from + hold_len);
         load[idx] = keep || (n == pulse_at);
         @(negedge clk);
         if (done[idx]) ok = 1'b1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      hold[idx] = 1'b0;
      load[idx] = keep;
      chk($sformatf("inst%0d done seen", idx), 64'(ok), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b1;
      load  = '0;
      hold  = '0;
      for (int i = 0; i < 3; i++) din_a[i] = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst READY", 64'(ready[0]), 64'd1);
      chk("rst BUSY",  64'(busy[0]),  64'd0);
      chk("rst EC",    64'(ec[0]),    64'd1);
      chk("rst DONE",  64'(done[2]),  64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 8'hA5, no parity, stray LOAD while busy
      start(0, 32'hA5, 1'b0);
      track(0, -1, 0, 2, 1'b0, n);
      chk("A5 length", 64'(n), 64'd8);
      chk("A5 rx", 64'(rx[0][7:0]), 64'hA5);
      chk("A5 transfers", 64'(xf[0]), 64'd8);

      // 8'h07 with even parity -> 9 bits, last = 1
      start(1, 32'h07, 1'b0);
      track(1, -1, 0, -1, 1'b0, n);
      chk("07p length", 64'(n), 64'd9);
      chk("07p rx", 64'(rx[1][8:0]), 64'h00F);
      chk("07p transfers", 64'(xf[1]), 64'd9);

      // 8'h3C with a 3-cycle stall after the 4th transfer
      start(0, 32'h3C, 1'b0);
      track(0, 4, 3, -1, 1'b0, n);
      chk("3C hold length", 64'(n), 64'd11);
      chk("3C rx", 64'(rx[0][7:0]), 64'h3C);
      chk("3C transfers", 64'(xf[0]), 64'd8);

      // LOAD held high: FF then 00, one idle cycle between frames
      start(0, 32'hFF, 1'b1);
      track(0, -1, 0, -1, 1'b1, n);
      chk("FF length", 64'(n), 64'd8);
      chk("FF rx", 64'(rx[0][7:0]), 64'hFF);
      chk("gap READY", 64'(ready[0]), 64'd1);
      @(posedge clk); #1;
      chk("b2b READY", 64'(ready[0]), 64'd0);
      chk("b2b BUSY", 64'(busy[0]), 64'd1);
      track(0, -1, 0, -1, 1'b1, n);
      load[0] = 1'b0;
      chk("00 length", 64'(n), 64'd8);
      chk("00 rx", 64'(rx[0][7:0]), 64'h00);
      chk("00 transfers", 64'(xf[0]), 64'd8);

      // minimum width
      start(2, 32'h2, 1'b0);
      track(2, -1, 0, -1, 1'b0, n);
      chk("w2 length", 64'(n), 64'd2);
      chk("w2 rx", 64'(rx[2][1:0]), 64'h2);
      chk("w2 transfers", 64'(xf[2]), 64'd2);

      // async reset mid-frame after 3 bits of 8'hA5
      start(0, 32'hA5, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk("mid BUSY before", 64'(busy[0]), 64'd1);
      chk("mid rx", 64'(rx[0][2:0]), 64'h5);
      rst_n = 1'b0;
      #1;
      chk("mid READY", 64'(ready[0]), 64'd1);
      chk("mid BUSY",  64'(busy[0]),  64'd0);
      chk("mid D",     64'(d[0]),     64'd0);
      chk("mid EC",    64'(ec[0]),    64'd1);
      chk("mid DONE",  64'(done[0]),  64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post rst READY", 64'(ready[0]), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
